// File: rtl/reg_slice.sv
// Valid/ready register slice with a one-entry skid buffer. Both the forward path
// (valid/data) and the backward path (ready) come straight from flops.
module reg_slice #(
    parameter int DW = 1
) (
    input  logic          clk,
    input  logic          nreset,
    input  logic          in_valid,
    input  logic [DW-1:0] in_data,
    output logic          in_ready,
    output logic          out_valid,
    output logic [DW-1:0] out_data,
    input  logic          out_ready,
    output logic [1:0]    level
);

    logic          main_valid_q, main_valid_d;
    logic [DW-1:0] main_data_q,  main_data_d;
    logic          skid_valid_q, skid_valid_d;
    logic [DW-1:0] skid_data_q,  skid_data_d;
    logic          in_xfer, out_xfer;

    assign in_xfer  = in_valid & ~skid_valid_q;
    assign out_xfer = main_valid_q & out_ready;

    always_comb begin
        main_valid_d = main_valid_q;
        main_data_d  = main_data_q;
        skid_valid_d = skid_valid_q;
        skid_data_d  = skid_data_q;
        if (!main_valid_q) begin
            if (in_xfer) begin
                main_valid_d = 1'b1;
                main_data_d  = in_data;
            end
        end else if (!skid_valid_q) begin
            // Single entry: pass-through, drain, or spill the new word into skid.
            if (out_xfer && in_xfer) begin
                main_data_d  = in_data;
            end else if (out_xfer) begin
                main_valid_d = 1'b0;
            end else if (in_xfer) begin
                skid_valid_d = 1'b1;
                skid_data_d  = in_data;
            end
        end else if (out_xfer) begin
            main_data_d  = skid_data_q;
            skid_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            main_valid_q <= 1'b0;
            main_data_q  <= '0;
            skid_valid_q <= 1'b0;
            skid_data_q  <= '0;
        end else begin
            main_valid_q <= main_valid_d;
            main_data_q  <= main_data_d;
            skid_valid_q <= skid_valid_d;
            skid_data_q  <= skid_data_d;
        end
    end

    assign in_ready  = ~skid_valid_q;
    assign out_valid = main_valid_q;
    assign out_data  = main_data_q;
    assign level     = {1'b0, main_valid_q} + {1'b0, skid_valid_q};

endmodule

// File: tb/tb_reg_slice.sv
// Randomized and directed bench for reg_slice; a two-deep FIFO queue is the reference.
module tb_reg_slice;

    localparam int DW = 8;

    logic          clk;
    logic          nreset;
    logic          in_valid;
    logic [DW-1:0] in_data;
    logic          in_ready;
    logic          out_valid;
    logic [DW-1:0] out_data;
    logic          out_ready;
    logic [1:0]    level;

    int n_cmp = 0;
    int n_bad = 0;
    logic [DW-1:0] mq[$];

    reg_slice #(.DW(DW)) dut (
        .clk(clk), .nreset(nreset),
        .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
        .out_valid(out_valid), .out_data(out_data), .out_ready(out_ready),
        .level(level)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Compare all outputs against the queue model.
    task automatic chk_model(input string tag);
        chk({tag, ".in_ready"},  {31'd0, in_ready},  {31'd0, mq.size() < 2});
        chk({tag, ".out_valid"}, {31'd0, out_valid}, {31'd0, mq.size() > 0});
        chk({tag, ".level"},     {30'd0, level},     mq.size());
        if (mq.size() > 0) chk({tag, ".out_data"}, {24'd0, out_data}, {24'd0, mq[0]});
    endtask

    // One clock: apply inputs, check at negedge, advance model at posedge.
    task automatic cycle(input string tag, input logic v, input logic [DW-1:0] d, input logic r);
        bit ix, ox;
        logic [DW-1:0] popped;
        in_valid  = v;
        in_data   = d;
        out_ready = r;
        @(negedge clk);
        chk_model(tag);
        ix = v && (mq.size() < 2);
        ox = r && (mq.size() > 0);
        @(posedge clk);
        if (ox) popped = mq.pop_front();
        if (ix) mq.push_back(d);
        #1;
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, ".out_valid"}, {31'd0, out_valid}, 0);
        chk({tag, ".out_data"},  {24'd0, out_data},  0);
        chk({tag, ".level"},     {30'd0, level},     0);
        chk({tag, ".in_ready"},  {31'd0, in_ready},  1);
    endtask

    initial begin
        nreset = 1'b0; in_valid = 1'b1; in_data = 8'hAA; out_ready = 1'b0;
        // Reset with active inputs: inputs must be ignored across edges.
        repeat (2) @(posedge clk);
        #2;
        chk_reset_vals("rst");
        nreset = 1'b1;
        cycle("rst_rel", 1'b1, 8'hAA, 1'b0);
        chk("rst_first_valid", {31'd0, out_valid}, 1);
        chk("rst_first_data", {24'd0, out_data}, 32'hAA);
        cycle("rst_drain", 1'b0, 8'h00, 1'b1);

        // Streaming at full rate.
        for (int i = 1; i <= 16; i++) cycle("stream", 1'b1, i[DW-1:0], 1'b1);
        cycle("stream_end", 1'b0, 8'h00, 1'b1);

        // Backpressure fill, then release.
        cycle("bp", 1'b1, 8'h11, 1'b0);
        cycle("bp", 1'b1, 8'h22, 1'b0);
        chk("bp_full_level", {30'd0, level}, 2);
        chk("bp_full_ready", {31'd0, in_ready}, 0);
        cycle("bp", 1'b1, 8'h33, 1'b0);
        cycle("bp_rel", 1'b1, 8'h33, 1'b1);
        cycle("bp_rel", 1'b1, 8'h33, 1'b1);
        cycle("bp_rel", 1'b0, 8'h00, 1'b1);
        cycle("bp_rel", 1'b0, 8'h00, 1'b1);

        // Mid-operation reset from FULL.
        cycle("mrst", 1'b1, 8'h44, 1'b0);
        cycle("mrst", 1'b1, 8'h55, 1'b0);
        chk("mrst_full", {30'd0, level}, 2);
        #1 nreset = 1'b0;
        #1;
        chk_reset_vals("mrst_async");
        mq.delete();
        #1 nreset = 1'b1;
        cycle("mrst_66", 1'b1, 8'h66, 1'b0);
        chk("mrst_first", {24'd0, out_data}, 32'h66);
        cycle("mrst_out", 1'b0, 8'h00, 1'b1);

        // Drain from FULL.
        cycle("drain", 1'b1, 8'h77, 1'b0);
        cycle("drain", 1'b1, 8'h88, 1'b0);
        chk("drain_l2", {30'd0, level}, 2);
        cycle("drain", 1'b0, 8'h00, 1'b1);
        chk("drain_l1", {30'd0, level}, 1);
        chk("drain_rdy", {31'd0, in_ready}, 1);
        cycle("drain", 1'b0, 8'h00, 1'b1);
        chk("drain_l0", {30'd0, level}, 0);
        chk("drain_ov", {31'd0, out_valid}, 0);

        // Random stall traffic.
        for (int i = 0; i < 10000; i++)
            cycle("rand", 1'($urandom_range(0, 1)), 8'($urandom), 1'($urandom_range(0, 1)));
        for (int i = 0; i < 3; i++) cycle("rand_flush", 1'b0, 8'h00, 1'b1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
